// File: rtl/fetch_controller.sv
// Superscalar fetch sequencer: owns the fetch PC, issues credit-limited
// fetch groups, and squashes/flushes on branch redirect.
module fetch_controller #(
    parameter int          FETCH_WIDTH = 4,
    parameter int          IBUF_DEPTH  = 16,
    parameter logic [15:0] RESET_PC    = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_target,
    input  logic        halt_req,
    input  logic [2:0]  ibuf_pop_count,
    output logic        fetch_valid,
    output logic [15:0] fetch_pc,
    output logic [2:0]  num_fetch,
    output logic        resp_valid,
    output logic [2:0]  resp_count,
    output logic [15:0] resp_pc,
    output logic        ibuf_flush,
    output logic        halted
);

    localparam int OW = $clog2(IBUF_DEPTH + 1);

    typedef enum logic [1:0] {RUN, FLUSH, HALT} state_t;

    state_t        state, state_nxt;
    logic [15:0]   pc, pc_nxt;
    logic [15:0]   inflight_pc, inflight_pc_nxt;
    logic [2:0]    inflight_cnt, inflight_cnt_nxt;
    logic [OW-1:0] occ, occ_nxt;
    logic [OW:0]   free;
    logic [OW:0]   sum;
    logic [OW:0]   pop;
    logic [2:0]    grant;

    // Credits count both buffered entries and the group still in the cache.
    assign free = (OW+1)'(IBUF_DEPTH) - {1'b0, occ}
                - (OW+1)'(inflight_cnt);
    assign grant = (free >= (OW+1)'(FETCH_WIDTH))
                 ? 3'(FETCH_WIDTH) : 3'(free);

    assign resp_valid = (inflight_cnt != 3'd0) && (state != FLUSH);
    assign resp_count = inflight_cnt;
    assign resp_pc    = inflight_pc;
    assign fetch_pc   = pc;

    assign sum = {1'b0, occ}
               + (resp_valid ? (OW+1)'(inflight_cnt) : '0);
    assign pop = ((OW+1)'(ibuf_pop_count) > sum)
               ? sum : (OW+1)'(ibuf_pop_count);

    always_comb begin
        state_nxt        = state;
        pc_nxt           = pc;
        inflight_cnt_nxt = inflight_cnt;
        inflight_pc_nxt  = inflight_pc;
        occ_nxt          = OW'(sum - pop);
        fetch_valid      = 1'b0;
        num_fetch        = 3'd0;
        ibuf_flush       = 1'b0;
        halted           = 1'b0;

        unique case (state)
            RUN: begin
                num_fetch   = grant;
                fetch_valid = (grant != 3'd0);
            end
            FLUSH:   ibuf_flush = 1'b1;
            HALT:    halted     = 1'b1;
            default: ;
        endcase

        if (redirect_valid) begin
            pc_nxt           = redirect_target;
            inflight_cnt_nxt = 3'd0;
            state_nxt        = FLUSH;
        end else begin
            unique case (state)
                RUN: begin
                    // The group requested this cycle is already at the
                    // cache, so it stays in flight even when halting.
                    pc_nxt           = pc + 16'({num_fetch, 1'b0});
                    inflight_cnt_nxt = num_fetch;
                    inflight_pc_nxt  = pc;
                    state_nxt        = halt_req ? HALT : RUN;
                end
                default: begin
                    inflight_cnt_nxt = 3'd0;
                    state_nxt        = halt_req ? HALT : RUN;
                end
            endcase
        end

        if (state == FLUSH) begin
            occ_nxt = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= RUN;
            pc           <= RESET_PC;
            occ          <= '0;
            inflight_cnt <= 3'd0;
            inflight_pc  <= 16'h0000;
        end else begin
            state        <= state_nxt;
            pc           <= pc_nxt;
            occ          <= occ_nxt;
            inflight_cnt <= inflight_cnt_nxt;
            inflight_pc  <= inflight_pc_nxt;
        end
    end

endmodule

// File: tb/tb_fetch_controller.sv
// Directed + randomized bench for fetch_controller against a
// queue-based model of the instruction buffer.
module tb_fetch_controller;

    localparam int FW    = 4;
    localparam int DEPTH = 16;
    localparam int M_RUN = 0, M_FLUSH = 1, M_HALT = 2;

    logic        clk;
    logic        rst;
    logic        redirect_valid;
    logic [15:0] redirect_target;
    logic        halt_req;
    logic [2:0]  ibuf_pop_count;
    logic        fetch_valid;
    logic [15:0] fetch_pc;
    logic [2:0]  num_fetch;
    logic        resp_valid;
    logic [2:0]  resp_count;
    logic [15:0] resp_pc;
    logic        ibuf_flush;
    logic        halted;

    int compared   = 0;
    int mismatched = 0;

    logic [15:0] buf_q[$];
    logic [15:0] m_pc;
    logic [15:0] m_ifl_pc;
    int          m_ifl_cnt;
    int          m_mode;

    fetch_controller dut (
        .clk             (clk),
        .rst             (rst),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .halt_req        (halt_req),
        .ibuf_pop_count  (ibuf_pop_count),
        .fetch_valid     (fetch_valid),
        .fetch_pc        (fetch_pc),
        .num_fetch       (num_fetch),
        .resp_valid      (resp_valid),
        .resp_count      (resp_count),
        .resp_pc         (resp_pc),
        .ibuf_flush      (ibuf_flush),
        .halted          (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        buf_q.delete();
        m_pc      = 16'h0000;
        m_ifl_pc  = 16'h0000;
        m_ifl_cnt = 0;
        m_mode    = M_RUN;
    endtask

    // One clock: drive inputs, compare against model, advance both.
    task automatic cycle(input logic rs, input logic rv,
                         input logic [15:0] tgt, input logic hr,
                         input int pop_n);
        int  free, nf, npop;
        bit  rsp;
        rst             = rs;
        redirect_valid  = rv;
        redirect_target = tgt;
        halt_req        = hr;
        ibuf_pop_count  = 3'(pop_n);

        free = DEPTH - buf_q.size() - m_ifl_cnt;
        nf   = (m_mode == M_RUN) ? ((free < FW) ? free : FW) : 0;
        rsp  = (m_ifl_cnt != 0) && (m_mode != M_FLUSH);

        chk("fetch_valid", 16'(fetch_valid), 16'(nf != 0));
        chk("num_fetch", 16'(num_fetch), 16'(nf));
        chk("fetch_pc", fetch_pc, m_pc);
        chk("resp_valid", 16'(resp_valid), 16'(rsp));
        if (rsp) begin
            chk("resp_count", 16'(resp_count), 16'(m_ifl_cnt));
            chk("resp_pc", resp_pc, m_ifl_pc);
        end
        chk("ibuf_flush", 16'(ibuf_flush), 16'(m_mode == M_FLUSH));
        chk("halted", 16'(halted), 16'(m_mode == M_HALT));

        @(posedge clk);

        if (rs) begin
            model_reset();
        end else begin
            if (m_mode == M_FLUSH) begin
                buf_q.delete();
            end else begin
                if (rsp)
                    for (int i = 0; i < m_ifl_cnt; i++)
                        buf_q.push_back(m_ifl_pc + 16'(2 * i));
                npop = (pop_n < buf_q.size()) ? pop_n : buf_q.size();
                repeat (npop) void'(buf_q.pop_front());
            end
            if (rv) begin
                m_pc      = tgt;
                m_ifl_cnt = 0;
                m_mode    = M_FLUSH;
            end else if (m_mode == M_RUN) begin
                m_ifl_cnt = nf;
                m_ifl_pc  = m_pc;
                m_pc      = m_pc + 16'(2 * nf);
                m_mode    = hr ? M_HALT : M_RUN;
            end else begin
                m_ifl_cnt = 0;
                m_mode    = hr ? M_HALT : M_RUN;
            end
        end
        #1;
    endtask

    task automatic idle(input int pop_n);
        cycle(1'b0, 1'b0, 16'h0, 1'b0, pop_n);
    endtask

    initial begin
        rst             = 1'b1;
        redirect_valid  = 1'b0;
        redirect_target = 16'h0;
        halt_req        = 1'b0;
        ibuf_pop_count  = 3'd0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();

        // Reset state
        rst = 1'b0;
        chk("rst_fetch_valid", 16'(fetch_valid), 16'd1);
        chk("rst_num_fetch", 16'(num_fetch), 16'd4);
        chk("rst_fetch_pc", fetch_pc, 16'h0000);
        chk("rst_resp_valid", 16'(resp_valid), 16'd0);
        chk("rst_flush", 16'(ibuf_flush), 16'd0);
        chk("rst_halted", 16'(halted), 16'd0);

        // Fill to full
        idle(0);
        chk("fill_pc1", fetch_pc, 16'h0008);
        idle(0);
        chk("fill_pc2", fetch_pc, 16'h0010);
        idle(0);
        chk("fill_pc3", fetch_pc, 16'h0018);
        chk("fill_nf3", 16'(num_fetch), 16'd4);
        idle(0);
        chk("full_fv", 16'(fetch_valid), 16'd0);
        idle(0);
        idle(0);
        chk("full_fv2", 16'(fetch_valid), 16'd0);
        chk("full_resp", 16'(resp_valid), 16'd0);

        // Partial credit
        idle(3);
        chk("part_nf", 16'(num_fetch), 16'd3);
        chk("part_pc", fetch_pc, 16'h0020);
        idle(0);
        chk("part_pc2", fetch_pc, 16'h0026);
        chk("part_fv2", 16'(fetch_valid), 16'd0);
        idle(4);
        idle(0);

        // Redirect squash with a group in flight
        chk("sq_resp_pre", 16'(resp_valid), 16'd1);
        cycle(1'b0, 1'b1, 16'h0100, 1'b0, 0);
        chk("sq_flush", 16'(ibuf_flush), 16'd1);
        chk("sq_resp", 16'(resp_valid), 16'd0);
        idle(0);
        chk("sq_pc", fetch_pc, 16'h0100);
        chk("sq_nf", 16'(num_fetch), 16'd4);

        // PC wrap
        cycle(1'b0, 1'b1, 16'hFFFC, 1'b0, 0);
        idle(0);
        chk("wrap_pc0", fetch_pc, 16'hFFFC);
        chk("wrap_nf", 16'(num_fetch), 16'd4);
        idle(0);
        chk("wrap_pc1", fetch_pc, 16'h0004);

        // Halt with a group in flight
        cycle(1'b0, 1'b0, 16'h0, 1'b1, 0);
        chk("halt_h", 16'(halted), 16'd1);
        chk("halt_resp", 16'(resp_valid), 16'd1);
        chk("halt_fv", 16'(fetch_valid), 16'd0);
        cycle(1'b0, 1'b0, 16'h0, 1'b1, 0);
        chk("halt_resp2", 16'(resp_valid), 16'd0);
        cycle(1'b0, 1'b0, 16'h0, 1'b1, 0);
        idle(0);
        chk("resume_h", 16'(halted), 16'd0);
        chk("resume_pc", fetch_pc, 16'h000C);
        chk("resume_fv", 16'(fetch_valid), 16'd1);

        // Redirect together with halt
        cycle(1'b0, 1'b1, 16'h0200, 1'b1, 0);
        chk("rh_flush", 16'(ibuf_flush), 16'd1);
        cycle(1'b0, 1'b0, 16'h0, 1'b1, 0);
        chk("rh_halted", 16'(halted), 16'd1);
        chk("rh_flush2", 16'(ibuf_flush), 16'd0);
        idle(0);
        chk("rh_pc", fetch_pc, 16'h0200);

        // Redirect during FLUSH
        cycle(1'b0, 1'b1, 16'h0300, 1'b0, 0);
        cycle(1'b0, 1'b1, 16'h0400, 1'b0, 0);
        chk("rr_flush", 16'(ibuf_flush), 16'd1);
        idle(0);
        chk("rr_flush2", 16'(ibuf_flush), 16'd0);
        chk("rr_pc", fetch_pc, 16'h0400);

        // Reset during FLUSH
        cycle(1'b0, 1'b1, 16'h0500, 1'b0, 0);
        cycle(1'b1, 1'b0, 16'h0, 1'b0, 0);
        chk("rf_flush", 16'(ibuf_flush), 16'd0);
        chk("rf_pc", fetch_pc, 16'h0000);
        chk("rf_fv", 16'(fetch_valid), 16'd1);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            cycle(($urandom_range(0, 199) == 0),
                  ($urandom_range(0, 19) == 0),
                  16'($urandom) & 16'hFFFE,
                  ($urandom_range(0, 9) == 0),
                  int'($urandom_range(0, 4)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
